// File: rtl/run_recognizer_p_if.sv
// Line-cell bus between the board scanner (master) and run_recognizer_p (slave).
interface run_recognizer_p_if #(
    parameter int PIECE_W = 2,
    parameter int WIN_LEN = 4,
    parameter int POS_W   = 3
);
    localparam int RL_W = $clog2(WIN_LEN + 1);

    logic               clear;
    logic               in_valid;
    logic [PIECE_W-1:0] in;
    logic [PIECE_W-1:0] out;
    logic [RL_W-1:0]    run_len;
    logic               win_pulse;
    logic [POS_W-1:0]   win_pos;
    logic [PIECE_W-1:0] win_piece;

    modport master (
        output clear, in_valid, in,
        input  out, run_len, win_pulse, win_pos, win_piece
    );

    modport slave (
        input  clear, in_valid, in,
        output out, run_len, win_pulse, win_pos, win_piece
    );
endinterface

// File: rtl/run_recognizer_p.sv
// Detects WIN_LEN consecutive identical non-empty pieces along a scanned line.
// Optional macro RUN_RECOGNIZER_STICKY_WIN_EN: win_piece/win_pos latch only the first win per line.
module run_recognizer_p #(
    parameter int PIECE_W = 2,
    parameter int WIN_LEN = 4,
    parameter int POS_W   = 3
) (
    input logic               next,
    input logic               reset,
    run_recognizer_p_if.slave bus
);
    localparam int RL_W = $clog2(WIN_LEN + 1);
    localparam logic [RL_W-1:0]  WIN_LEN_R = RL_W'(WIN_LEN);
    localparam logic [RL_W-1:0]  PRE_WIN_R = RL_W'(WIN_LEN - 1);
    localparam logic [POS_W-1:0] POS_MAX   = '1;

    logic [PIECE_W-1:0] cur_piece;
    logic [RL_W-1:0]    run_len;
    logic [POS_W-1:0]   pos;
    logic               win_pulse;
    logic [POS_W-1:0]   win_pos;

    logic [PIECE_W-1:0] base_piece;
    logic [RL_W-1:0]    base_len;
    logic [POS_W-1:0]   base_pos;
    logic [PIECE_W-1:0] nxt_piece;
    logic [RL_W-1:0]    nxt_len;
    logic [POS_W-1:0]   nxt_pos;
    logic               completes;

    // A clear makes the incoming sample the first cell of a fresh line.
    always_comb begin
        base_piece = bus.clear ? '0 : cur_piece;
        base_len   = bus.clear ? '0 : run_len;
        base_pos   = bus.clear ? '0 : pos;
        nxt_piece  = base_piece;
        nxt_len    = base_len;
        if (bus.in == '0) begin
            nxt_piece = '0;
            nxt_len   = '0;
        end else if (bus.in == base_piece) begin
            nxt_len = (base_len == WIN_LEN_R) ? WIN_LEN_R : base_len + 1'b1;
        end else begin
            nxt_piece = bus.in;
            nxt_len   = RL_W'(1);
        end
        nxt_pos   = (base_pos == POS_MAX) ? POS_MAX : base_pos + 1'b1;
        completes = bus.in_valid && (base_len == PRE_WIN_R) && (nxt_len == WIN_LEN_R);
    end

    assign bus.out       = (run_len == WIN_LEN_R) ? cur_piece : '0;
    assign bus.run_len   = run_len;
    assign bus.win_pulse = win_pulse;
    assign bus.win_pos   = win_pos;

`ifdef RUN_RECOGNIZER_STICKY_WIN_EN
    logic [PIECE_W-1:0] win_piece;
    logic               won;

    assign bus.win_piece = win_piece;

    always_ff @(posedge next) begin
        if (!reset) begin
            cur_piece <= '0;
            run_len   <= '0;
            pos       <= '0;
            win_pulse <= 1'b0;
            win_pos   <= '0;
            win_piece <= '0;
            won       <= 1'b0;
        end else if (bus.clear || bus.in_valid) begin
            if (bus.in_valid) begin
                cur_piece <= nxt_piece;
                run_len   <= nxt_len;
                pos       <= nxt_pos;
            end else begin
                cur_piece <= '0;
                run_len   <= '0;
                pos       <= '0;
            end
            win_pulse <= completes;
            if (bus.clear) begin
                win_piece <= '0;
                won       <= 1'b0;
            end else if (completes && !won) begin
                win_piece <= nxt_piece;
                win_pos   <= base_pos;
                won       <= 1'b1;
            end
        end else begin
            win_pulse <= 1'b0;
        end
    end
`else
    assign bus.win_piece = bus.out;

    always_ff @(posedge next) begin
        if (!reset) begin
            cur_piece <= '0;
            run_len   <= '0;
            pos       <= '0;
            win_pulse <= 1'b0;
            win_pos   <= '0;
        end else if (bus.clear || bus.in_valid) begin
            if (bus.in_valid) begin
                cur_piece <= nxt_piece;
                run_len   <= nxt_len;
                pos       <= nxt_pos;
            end else begin
                cur_piece <= '0;
                run_len   <= '0;
                pos       <= '0;
            end
            win_pulse <= completes;
            if (completes)
                win_pos <= base_pos;
        end else begin
            win_pulse <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_run_recognizer_p.sv
// Scoreboard bench for run_recognizer_p: a line-history model predicts every edge, a monitor compares.
module tb_run_recognizer_p;
    localparam int PIECE_W = 2;
    localparam int WIN_LEN = 4;
    localparam int POS_W   = 3;
    localparam int POS_MAX = (1 << POS_W) - 1;

    typedef struct {
        int out;
        int run_len;
        int win_pulse;
        int win_pos;
        int win_piece;
    } expect_t;

    logic next;
    logic reset;

    run_recognizer_p_if #(.PIECE_W(PIECE_W), .WIN_LEN(WIN_LEN), .POS_W(POS_W)) bus ();

    run_recognizer_p #(.PIECE_W(PIECE_W), .WIN_LEN(WIN_LEN), .POS_W(POS_W)) dut (
        .next  (next),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        next = 1'b0;
        forever #5 next = ~next;
    end

    expect_t exp_q[$];
    int      checks = 0;
    int      errors = 0;

    // Model state: the cells seen since the line began, plus the reported win.
    int line_q[$];
    int m_win_pos    = 0;
    int m_sticky_pc  = 0;
    bit m_won        = 0;
    int m_pulse      = 0;
    int prev_piece   = 1;

    function automatic int trailing_run();
        int n;
        int last;
        if (line_q.size() == 0) return 0;
        last = line_q[line_q.size()-1];
        if (last == 0) return 0;
        n = 0;
        for (int i = line_q.size() - 1; i >= 0; i--) begin
            if (line_q[i] != last) break;
            n++;
        end
        return n;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit rst_n, input bit clr, input bit vld, input int pc);
        expect_t e;
        int      idx;
        int      r;
        @(negedge next);
        reset        = rst_n;
        bus.clear    = clr;
        bus.in_valid = vld;
        bus.in       = PIECE_W'(pc);
        m_pulse = 0;
        if (!rst_n) begin
            line_q.delete();
            m_win_pos   = 0;
            m_sticky_pc = 0;
            m_won       = 0;
        end else begin
            if (clr) begin
                line_q.delete();
                m_sticky_pc = 0;
                m_won       = 0;
            end
            if (vld) begin
                idx = (line_q.size() > POS_MAX) ? POS_MAX : line_q.size();
                line_q.push_back(pc);
                if (trailing_run() == WIN_LEN) begin
                    m_pulse = 1;
`ifdef RUN_RECOGNIZER_STICKY_WIN_EN
                    if (!m_won) begin
                        m_won       = 1;
                        m_win_pos   = idx;
                        m_sticky_pc = pc;
                    end
`else
                    m_win_pos = idx;
`endif
                end
            end
        end
        r = trailing_run();
        e.run_len   = (r > WIN_LEN) ? WIN_LEN : r;
        e.out       = (e.run_len == WIN_LEN) ? line_q[line_q.size()-1] : 0;
        e.win_pulse = m_pulse;
        e.win_pos   = m_win_pos;
`ifdef RUN_RECOGNIZER_STICKY_WIN_EN
        e.win_piece = m_sticky_pc;
`else
        e.win_piece = e.out;
`endif
        exp_q.push_back(e);
    endtask

    task automatic feed_line(input int cells[$], input bit gaps);
        foreach (cells[i]) begin
            apply_stimulus(1, 0, 1, cells[i]);
            if (gaps) apply_stimulus(1, 0, 0, 3);
        end
    endtask

    // Monitor: every edge that had stimulus yields one scoreboard entry.
    always @(posedge next) begin
        expect_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("out",       int'(bus.out),       e.out);
            check_output("run_len",   int'(bus.run_len),   e.run_len);
            check_output("win_pulse", int'(bus.win_pulse), e.win_pulse);
            check_output("win_pos",   int'(bus.win_pos),   e.win_pos);
            check_output("win_piece", int'(bus.win_piece), e.win_piece);
        end
    end

    initial begin
        int pc;
        reset        = 1'b0;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in       = '0;
        $display("[TB] start");

        apply_stimulus(0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 1);
        feed_line('{1, 1, 1, 1}, 0);
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0);
        feed_line('{1, 1, 1, 2, 2, 2, 2}, 0);
        apply_stimulus(1, 1, 0, 0);
        feed_line('{1, 1, 0, 1, 1, 1, 1}, 1);
        feed_line('{1, 1}, 0);
        apply_stimulus(1, 1, 1, 2);
        apply_stimulus(1, 1, 0, 0);
        feed_line('{3, 3, 3}, 0);
        apply_stimulus(0, 0, 1, 3);
        feed_line('{1, 1, 1, 1}, 0);
        apply_stimulus(1, 1, 0, 0);
        feed_line('{2, 2, 2, 2, 1, 1, 1, 1}, 0);
        apply_stimulus(1, 1, 0, 0);
        feed_line('{1, 2, 3, 1, 2, 3, 3, 3, 3, 3, 3}, 0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) prev_piece = $urandom_range(0, 3);
            pc = prev_piece;
            apply_stimulus($urandom_range(0, 99) != 0, $urandom_range(0, 11) == 0,
                           $urandom_range(0, 3) != 0, pc);
        end

        apply_stimulus(1, 0, 0, 0);
        @(negedge next);
        @(negedge next);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
